fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end. It replaces the bare pc register and next-pc mux chain with a PC sequencer that prefetches into a queue.
- It issues word-addressed reads to a synchronous instruction memory with 1-cycle read latency.
- It buffers returned words in a DEPTH-entry prefetch queue and presents them to decode with a valid/ready handshake.
- It handles redirects by priority, jr > jump > taken beq/bne. A redirect kills the in-flight read and flushes the queue.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF  = 13;
  localparam int unsigned INSTR_W_DEF = 32;

  // One prefetch queue entry at the default widths: PC in the upper bits.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

  // Which source, if any, redirects the PC this cycle.
  typedef enum logic [1:0] {
    RS_NONE,
    RS_BRANCH,
    RS_JUMP,
    RS_JR
  } redirect_src_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through FIFO with a synchronous flush.
// The head is visible the cycle after the push; it reads as zero when empty.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 45,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push & (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop & (count_q != '0);

  // Next-state for pointers and occupancy; flush discards everything.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC sequencer issuing reads to a 1-cycle
// synchronous instruction memory, prefetching into a FWFT queue, with
// prioritised redirects (jr > jump > taken branch) that kill and reload.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       INSTR_W  = INSTR_W_DEF,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst_data,
  output logic [ADDR_W-1:0]  inst_pc,
  input  logic               br_valid,
  input  logic               br_is_bne,
  input  logic               br_zero,
  input  logic [ADDR_W-1:0]  br_pc,
  input  logic [ADDR_W-1:0]  br_offset,
  input  logic               jump_valid,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               jr_valid,
  input  logic [ADDR_W-1:0]  jr_target
);

  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  tag_q, tag_d;
  logic               inflight_q, inflight_d;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W:0]     occupancy;
  logic               pop, taken, redirect, push;
  redirect_src_t      src;
  logic [ADDR_W-1:0]  target;

  assign pop      = inst_valid & inst_ready;
  assign taken    = br_valid & (br_zero ^ br_is_bne);
  assign redirect = (src != RS_NONE);

  // Redirect source selection by priority.
  always_comb begin
    src = RS_NONE;
    if (jr_valid)        src = RS_JR;
    else if (jump_valid) src = RS_JUMP;
    else if (taken)      src = RS_BRANCH;
  end

  // Redirect target mux; the branch sum wraps modulo 2^ADDR_W.
  always_comb begin
    target = pc_q;
    unique case (src)
      RS_JR:     target = jr_target;
      RS_JUMP:   target = jump_target;
      RS_BRANCH: target = br_pc + ADDR_W'(1) + br_offset;
      default:   target = pc_q;
    endcase
  end

  // Entries the queue will hold once the outstanding read lands and this
  // cycle's pop retires; a request is only made if that leaves room.
  assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
  assign imem_req  = !reset && !redirect && (occupancy < (CNT_W + 1)'(DEPTH));
  assign imem_addr = pc_q;

  // A response arriving in a redirect cycle belongs to the killed stream.
  assign push = inflight_q & !redirect;

  // Next-state for the pc and the outstanding-read tag.
  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = imem_req;
    if (redirect) begin
      pc_d = target;
    end else if (imem_req) begin
      pc_d  = pc_q + ADDR_W'(1);
      tag_d = pc_q;
    end
  end

  // PC and inflight/tag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .pop       (pop),
    .push_data ({tag_q, imem_rdata}),
    .count     (count),
    .head      (head)
  );

  assign inst_valid = (count != '0);
  assign inst_pc    = head[ENTRY_W-1:INSTR_W];
  assign inst_data  = head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (DEPTH=2 from PC 0, DEPTH=1 from 0x1FFE)
// share redirect/ready stimulus and are compared cycle by cycle against a
// queue-level reference model of the fetch front end.
module tb_fetch_unit;

  localparam int DEPTHS [2] = '{2, 1};

  logic        clk;
  logic        reset;
  logic        inst_ready;
  logic        br_valid, br_is_bne, br_zero;
  logic [12:0] br_pc, br_offset;
  logic        jump_valid, jr_valid;
  logic [12:0] jump_target, jr_target;

  logic [1:0]  req;
  logic [12:0] addr  [2];
  logic [31:0] rdata [2];
  logic [1:0]  valid;
  logic [31:0] data  [2];
  logic [12:0] ipc   [2];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state per instance.
  logic [12:0] m_pc   [2];
  logic [12:0] m_q    [2][4];
  int          m_cnt  [2];
  bit          m_infl [2];
  logic [12:0] m_tag  [2];
  bit          armed = 0;
  bit          after_reset = 0;

  fetch_unit #(.ADDR_W(13), .INSTR_W(32), .DEPTH(2), .RESET_PC(13'h0000)) u_dut0 (
    .clk(clk), .reset(reset), .imem_req(req[0]), .imem_addr(addr[0]),
    .imem_rdata(rdata[0]), .inst_valid(valid[0]), .inst_ready(inst_ready),
    .inst_data(data[0]), .inst_pc(ipc[0]), .br_valid(br_valid), .br_is_bne(br_is_bne),
    .br_zero(br_zero), .br_pc(br_pc), .br_offset(br_offset), .jump_valid(jump_valid),
    .jump_target(jump_target), .jr_valid(jr_valid), .jr_target(jr_target)
  );

  fetch_unit #(.ADDR_W(13), .INSTR_W(32), .DEPTH(1), .RESET_PC(13'h1FFE)) u_dut1 (
    .clk(clk), .reset(reset), .imem_req(req[1]), .imem_addr(addr[1]),
    .imem_rdata(rdata[1]), .inst_valid(valid[1]), .inst_ready(inst_ready),
    .inst_data(data[1]), .inst_pc(ipc[1]), .br_valid(br_valid), .br_is_bne(br_is_bne),
    .br_zero(br_zero), .br_pc(br_pc), .br_offset(br_offset), .jump_valid(jump_valid),
    .jump_target(jump_target), .jr_valid(jr_valid), .jr_target(jr_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: 1-cycle read, word = zero-extended address.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) rdata[i] <= req[i] ? {19'b0, addr[i]} : 32'hDEAD_BEEF;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_ctl();
    br_valid = 0; br_is_bne = 0; br_zero = 0; br_pc = '0; br_offset = '0;
    jump_valid = 0; jump_target = '0; jr_valid = 0; jr_target = '0;
  endtask

  // Check outputs against the model for the current inputs, then advance
  // the model across the coming clock edge and wait for the next negedge.
  task automatic step();
    bit          taken, redir, pop, ereq, has;
    logic [12:0] tgt;
    int          occ;
    #1;
    taken = br_valid && (br_zero != br_is_bne);
    redir = jr_valid || jump_valid || taken;
    tgt   = jr_valid ? jr_target : (jump_valid ? jump_target : 13'(br_pc + 13'd1 + br_offset));
    for (int i = 0; i < 2; i++) begin
      has  = (m_cnt[i] > 0);
      pop  = has && inst_ready;
      occ  = m_cnt[i] + int'(m_infl[i]) - int'(pop);
      ereq = !reset && !redir && (occ < DEPTHS[i]);
      if (armed) begin
        check_eq($sformatf("u%0d.inst_valid", i), 32'(valid[i]), 32'(has));
        if (has) begin
          check_eq($sformatf("u%0d.inst_pc", i), 32'(ipc[i]), 32'(m_q[i][0]));
          check_eq($sformatf("u%0d.inst_data", i), data[i], {19'b0, m_q[i][0]});
        end else if (after_reset) begin
          check_eq($sformatf("u%0d.reset_inst_pc", i), 32'(ipc[i]), 32'h0);
          check_eq($sformatf("u%0d.reset_inst_data", i), data[i], 32'h0);
        end
        check_eq($sformatf("u%0d.imem_req", i), 32'(req[i]), 32'(ereq));
        if (ereq) check_eq($sformatf("u%0d.imem_addr", i), 32'(addr[i]), 32'(m_pc[i]));
      end
      if (reset) begin
        m_pc[i]   = (i == 0) ? 13'h0000 : 13'h1FFE;
        m_cnt[i]  = 0;
        m_infl[i] = 0;
      end else begin
        if (pop) begin
          for (int k = 0; k < 3; k++) m_q[i][k] = m_q[i][k+1];
          m_cnt[i]--;
        end
        if (redir) begin
          m_cnt[i]  = 0;
          m_infl[i] = 0;
          m_pc[i]   = tgt;
        end else begin
          if (m_infl[i] && m_cnt[i] < 4) begin
            m_q[i][m_cnt[i]] = m_tag[i];
            m_cnt[i]++;
          end
          m_infl[i] = ereq;
          if (ereq) begin
            m_tag[i] = m_pc[i];
            m_pc[i]  = m_pc[i] + 13'd1;
          end
        end
      end
    end
    after_reset = reset;
    armed = armed | reset;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; inst_ready = 1; clear_ctl();
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = '0; m_cnt[i] = 0; m_infl[i] = 0; m_tag[i] = '0;
    end
    @(negedge clk);
    step(); step();
    reset = 0;
    repeat (8) step();

    // Backpressure: fill the queue, then release.
    inst_ready = 0; repeat (6) step();
    inst_ready = 1; repeat (6) step();

    // beq taken from 5 with offset -3 -> 3.
    br_valid = 1; br_is_bne = 0; br_zero = 1; br_pc = 13'd5; br_offset = 13'h1FFD;
    step(); clear_ctl(); repeat (6) step();

    // bne with zero=1: not taken; then bne with zero=0 from 10, +4 -> 15.
    br_valid = 1; br_is_bne = 1; br_zero = 1; br_pc = 13'd10; br_offset = 13'd4;
    step(); clear_ctl(); repeat (3) step();
    br_valid = 1; br_is_bne = 1; br_zero = 0; br_pc = 13'd10; br_offset = 13'd4;
    step(); clear_ctl(); repeat (6) step();

    // All three sources at once: jr wins.
    jr_valid = 1; jr_target = 13'h040; jump_valid = 1; jump_target = 13'h100;
    br_valid = 1; br_zero = 1; br_pc = 13'd20; br_offset = 13'd2;
    step(); clear_ctl(); repeat (5) step();

    // Back-to-back redirects: last one wins.
    jump_valid = 1; jump_target = 13'h200; step();
    jump_target = 13'h1FFF; step(); clear_ctl(); repeat (6) step();

    // Reset together with a redirect, then mid-stream reset.
    reset = 1; jump_valid = 1; jump_target = 13'h0AA; step();
    clear_ctl(); reset = 0; repeat (6) step();
    reset = 1; step(); reset = 0; repeat (6) step();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      inst_ready  = ($urandom_range(0, 3) != 0);
      reset       = ($urandom_range(0, 199) == 0);
      jr_valid    = ($urandom_range(0, 23) == 0);
      jr_target   = 13'($urandom);
      jump_valid  = ($urandom_range(0, 23) == 0);
      jump_target = 13'($urandom);
      br_valid    = ($urandom_range(0, 5) == 0);
      br_is_bne   = 1'($urandom);
      br_zero     = 1'($urandom);
      br_pc       = 13'($urandom);
      br_offset   = 13'($urandom_range(0, 31)) - 13'd16;
      step();
    end
    reset = 0; clear_ctl(); inst_ready = 1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
